// File: rtl/musa_pc_pkg.sv
// Shared definitions for the MUSA PC / return-stack unit: branch condition
// codes, flag bit positions and the branch condition evaluator.
package musa_pc_pkg;

  localparam logic [2:0] BR_ALWAYS = 3'b000;
  localparam logic [2:0] BR_ZERO   = 3'b001;
  localparam logic [2:0] BR_NEG    = 3'b010;
  localparam logic [2:0] BR_CARRY  = 3'b011;
  localparam logic [2:0] BR_OVF    = 3'b100;
  localparam logic [2:0] BR_NZERO  = 3'b101;
  localparam logic [2:0] BR_NNEG   = 3'b110;
  localparam logic [2:0] BR_NEVER  = 3'b111;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;

  function automatic logic cond_true(input logic [2:0] branch, input logic [3:0] flags);
    logic res;
    res = 1'b0;
    case (branch)
      BR_ALWAYS: res = 1'b1;
      BR_ZERO:   res = flags[FLG_ZERO];
      BR_NEG:    res = flags[FLG_NEG];
      BR_CARRY:  res = flags[FLG_CARRY];
      BR_OVF:    res = flags[FLG_OVF];
      BR_NZERO:  res = !flags[FLG_ZERO];
      BR_NNEG:   res = !flags[FLG_NEG];
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// Return-address LIFO: owns the entry memory, stack pointer, full/empty
// status and the sticky error flag for illegal stack operations.
module return_stack
  import musa_pc_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         pop_ok_o,
  output logic         err_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic            push_ok, pop_ok;
  logic [AW-1:0]   wr_idx, top_idx;

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SP_W'(DEPTH));

  // a simultaneous push and pop is rejected outright rather than treated as replace
  assign push_ok  = push_i && !pop_i && !full_o;
  assign pop_ok   = pop_i && !push_i && !empty_o;
  assign pop_ok_o = pop_ok;

  assign wr_idx  = sp_q[AW-1:0];
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign top_o   = empty_o ? '0 : mem_q[top_idx];
  assign err_o   = err_q;

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (push_ok) sp_d = sp_q + SP_W'(1);
    if (pop_ok)  sp_d = sp_q - SP_W'(1);
    if ((push_i && pop_i) || (push_i && full_o) || (pop_i && empty_o)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= din_i;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with priority next-PC selection and a return-address
// stack for call/ret sequencing in the MUSA core.
module pc_stack_unit
  import musa_pc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            add_pc,
  input  logic            write_pc,
  input  logic            brfl_control,
  input  logic [2:0]      branch,
  input  logic            push,
  input  logic            pop,
  input  logic            rtrn,
  input  logic [PC_W-1:0] target,
  input  logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] top,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            pop_ok;

  assign pc_inc = pc_q + PC_W'(1);

  return_stack #(.W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    (pc_inc),
    .top_o    (top),
    .empty_o  (stack_empty),
    .full_o   (stack_full),
    .pop_ok_o (pop_ok),
    .err_o    (stack_err)
  );

  // a return that cannot pop freezes the PC instead of falling through
  always_comb begin
    pc_d = pc_q;
    if (rtrn && pop) begin
      if (pop_ok) pc_d = top;
    end else if (write_pc && !brfl_control) begin
      pc_d = target;
    end else if (write_pc && brfl_control) begin
      pc_d = cond_true(branch, flags) ? target : pc_inc;
    end else if (add_pc) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and return-address-stack unit of the MUSA core. It consumes the flow-control outputs of the microprogrammed control unit (`write_pc`, `add_pc`, `brfl_control`, `branch`, `push`, `pop`, `rtrn`) together with a target address from the datapath and ALU flags. It sequences the PC for fetch and keeps a hardware LIFO of return addresses for `call`/`ret`.

## Interface
- `PC_W`, 16: PC and stack entry width (word addresses).
- `DEPTH`, 8: return-stack entries; power of two, at least 2.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `add_pc`  in  1  sequential increment, PC ← PC+1
- `write_pc`  in  1  load PC from `target` (jr/jpc/call), or conditional load when `brfl_control`=1
- `brfl_control`  in  1  qualifies `write_pc` as conditional (brfl)
- `branch`  in  3  condition select for brfl
- `push`  in  1  push return address PC+1
- `pop`  in  1  pop top entry
- `rtrn`  in  1  with `pop`: PC ← popped entry
- `target`  in  PC_W  jump/branch target from datapath
- `flags`  in  4  {ovf, carry, neg, zero}, bit 0 = zero
- `pc`  out  PC_W  current PC (registered)
- `top`  out  PC_W  current top-of-stack entry; 0 when empty
- `stack_empty`  out  1  sp == 0
- `stack_full`  out  1  sp == DEPTH
- `stack_err`  out  1  sticky overflow/underflow/illegal-op flag

## Operation
- Branch conditions: 000 always, 001 zero, 010 neg, 011 carry, 100 ovf, 101 !zero, 110 !neg, 111 never.
- PC next-state priority, highest first:
  - `rtrn&pop`, stack non-empty → PC ← top.
  - `write_pc&!brfl_control` → target.
  - `write_pc&brfl_control` → target if the condition is true, else PC+1.
  - `add_pc` → PC+1.
  - Otherwise hold.
- `rtrn` without `pop` is ignored.
- `push`: mem[sp] ← PC+1, sp ← sp+1. The PC for call is set by a coincident `write_pc`.
- `pop`: sp ← sp−1. `top` then shows mem[sp−2], or 0 if the stack becomes empty.
- Boundary conditions:
  - push when full: stack unchanged, `stack_err` ← 1; PC still follows its rules.
  - pop/rtrn when empty: stack unchanged, `stack_err` ← 1, PC holds (no fallback to other sources).
  - push&pop in the same cycle: illegal; stack unchanged, `stack_err` ← 1; PC rules still apply, with rtrn treated as empty-case hold.
- Arithmetic: PC+1 wraps modulo 2^PC_W. `sp` is $clog2(DEPTH)+1 bits wide.
- `stack_err` clears only on reset.

## Timing
- All state changes on the rising `clk`; outputs are registered and visible the cycle after the control strobe.
- Zero-bubble: back-to-back strobes on consecutive cycles are all honoured; e.g. push then pop returns the just-pushed value.
- `flags` and `target` are sampled on the same edge as the strobe.
- Reset (asynchronous, any time, including mid-call):
  - `pc`=RESET_PC, sp=0, `top`=0, `stack_empty`=1, `stack_full`=0, `stack_err`=0.
  - Stack memory contents are don't-care.
- Release of `rst_n` is synchronised by the system; the first strobe is acted on at the first edge after deassertion.

## Structure
- Package `musa_pc_pkg`:
  - branch condition codes (`BR_ALWAYS`…`BR_NEVER`) as 3-bit localparams;
  - flag bit indices `FLG_ZERO=0`, `FLG_NEG=1`, `FLG_CARRY=2`, `FLG_OVF=3`;
  - `cond_true(branch, flags)` function.
- Sub-module `return_stack`: parameterised LIFO owning mem, sp, `full`, `empty`, `top` and error detection; `pc_stack_unit` holds the PC register and priority mux.

## Test plan
- Reset, then `add_pc` for 3 cycles → `pc`=0,1,2,3; `stack_empty`=1.
- At pc=3, `push`+`write_pc`, target=0x40 → `pc`=0x40, `top`=4. Next cycle `pop`+`rtrn` → `pc`=4, `stack_empty`=1.
- brfl with branch=001, target=0x20:
  - flags=0001 → pc=0x20;
  - flags=0000 at pc=0x20 → pc=0x21;
  - branch=111 → never taken.
- DEPTH=8: nine pushes → `stack_full`=1 after the 8th; 9th sets `stack_err`, `top` unchanged. Eight pops return entries in LIFO order; a 9th pop+rtrn leaves pc held.
- push&pop same cycle → sp and `top` unchanged, `stack_err`=1.
- Wrap and reset:
  - pc=0xFFFF with `add_pc` → 0x0000.
  - Assert `rst_n`=0 mid-cycle with 3 entries stacked → outputs return to reset values immediately, before the next edge.
